// File: rtl/aec_bus_arbiter_pkg.sv
// Shared state encoding, requester indices and counter sizing for the AEC bus arbiter.
package aec_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic REQ_VIDEO = 1'b0;
  localparam logic REQ_EXP   = 1'b1;

  // Saturating counters need to hold max_val itself; a zero limit still gets one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_prio2.sv
// Two-way fixed-priority winner select; video wins unless the one-shot favour bit
// hands this arbitration to a pending expansion request.
module arb_prio2
  import aec_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       favour,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid = |req;
    if (favour && req[REQ_EXP]) begin
      winner = REQ_EXP;
    end else if (req[REQ_VIDEO]) begin
      winner = REQ_VIDEO;
    end else begin
      winner = REQ_EXP;
    end
  end

endmodule

// File: rtl/aec_bus_arbiter.sv
// Halts the 6502 core via RDY, waits out its write cycles, then hands the bus to a DMA
// requester by dropping AEC. State advances on the falling edge of phi2 (end of bus cycle).
module aec_bus_arbiter
  import aec_bus_arbiter_pkg::*;
#(
  parameter int MAX_STALL = 3,
  parameter int MAX_GRANT = 64,
  parameter int TURN      = 1
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic       r_w_6502,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       aec,
  output logic       rdy,
  output logic       timeout
);

  localparam int SW = cnt_width(MAX_STALL);
  localparam int GW = cnt_width(MAX_GRANT);
  localparam int TW = cnt_width(TURN);

  localparam logic [SW-1:0] STALL_LIMIT   = SW'(MAX_STALL);
  localparam logic [GW-1:0] GRANT_LIMIT   = GW'(MAX_GRANT);
  localparam logic [TW-1:0] TURN_LIMIT    = TW'(TURN);
  localparam bit            GRANT_LIMITED = (MAX_GRANT != 0);

  arb_state_e    state_q, state_d;
  logic          winner_q, winner_d;
  logic          favour_q, favour_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d, stall_inc;
  logic [GW-1:0] grant_cnt_q, grant_cnt_d, grant_inc;
  logic [TW-1:0] turn_cnt_q, turn_cnt_d, turn_inc;
  logic          aec_q, aec_d;
  logic          rdy_q, rdy_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          timeout_q, timeout_d;
  logic          arb_valid, arb_winner;

  arb_prio2 u_prio (
    .req    (req),
    .favour (favour_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  assign stall_inc = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + SW'(1);
  assign grant_inc = (grant_cnt_q == '1) ? grant_cnt_q : grant_cnt_q + GW'(1);
  assign turn_inc  = (turn_cnt_q  == '1) ? turn_cnt_q  : turn_cnt_q  + TW'(1);

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    favour_d    = favour_q;
    stall_cnt_d = stall_cnt_q;
    grant_cnt_d = grant_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d     = STALL;
          winner_d    = arb_winner;
          favour_d    = 1'b0;
          stall_cnt_d = '0;
        end
      end
      STALL: begin
        // A requester that gives up before owning the bus never gets a grant cycle.
        if (!req[winner_q]) begin
          if (arb_valid) begin
            winner_d    = arb_winner;
            favour_d    = 1'b0;
            stall_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (!r_w_6502) begin
            stall_cnt_d = stall_inc;
          end
          if (r_w_6502 || stall_cnt_d >= STALL_LIMIT) begin
            state_d     = GRANT;
            grant_cnt_d = '0;
          end
        end
      end
      GRANT: begin
        grant_cnt_d = grant_inc;
        if (!req[winner_q]) begin
          state_d    = RELEASE;
          turn_cnt_d = '0;
        end else if (GRANT_LIMITED && grant_inc >= GRANT_LIMIT) begin
          state_d    = RELEASE;
          turn_cnt_d = '0;
          timeout_d  = 1'b1;
          if (winner_q == REQ_VIDEO) begin
            favour_d = 1'b1;
          end
        end
      end
      default: begin
        turn_cnt_d = turn_inc;
        if (turn_inc >= TURN_LIMIT) begin
          if (arb_valid) begin
            state_d     = STALL;
            winner_d    = arb_winner;
            favour_d    = 1'b0;
            stall_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops already settled.
    aec_d = (state_d != GRANT);
    rdy_d = (state_d == IDLE);
    gnt_d = 2'b00;
    if (state_d == GRANT) begin
      gnt_d[winner_d] = 1'b1;
    end
  end

  always_ff @(negedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q     <= IDLE;
      winner_q    <= REQ_VIDEO;
      favour_q    <= 1'b0;
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
      turn_cnt_q  <= '0;
      aec_q       <= 1'b1;
      rdy_q       <= 1'b1;
      gnt_q       <= 2'b00;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      favour_q    <= favour_d;
      stall_cnt_q <= stall_cnt_d;
      grant_cnt_q <= grant_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      aec_q       <= aec_d;
      rdy_q       <= rdy_d;
      gnt_q       <= gnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign aec     = aec_q;
  assign rdy     = rdy_q;
  assign timeout = timeout_q;

endmodule
